// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response and byte-memory port bundle for mem_access_ctrl.
// MEM_ACCESS_CTRL_BYTE_EN adds the req_byte single-byte access qualifier.
interface mem_access_ctrl_if #(
  parameter int addresswidth = 7,
  parameter int width        = 8,
  parameter int wordbytes    = 4
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [addresswidth-1:0]       req_addr;
  logic [width*wordbytes-1:0]    req_wdata;
`ifdef MEM_ACCESS_CTRL_BYTE_EN
  logic                          req_byte;
`endif
  logic                          resp_valid;
  logic [width*wordbytes-1:0]    resp_rdata;
  logic [addresswidth-1:0]       mem_address;
  logic                          mem_writeEnable;
  logic [width-1:0]              mem_dataIn;
  logic [width-1:0]              mem_dataOut;

  modport slave (
`ifdef MEM_ACCESS_CTRL_BYTE_EN
    input  req_byte,
`endif
    input  req_valid, req_write, req_addr, req_wdata, mem_dataOut,
    output req_ready, resp_valid, resp_rdata, mem_address, mem_writeEnable, mem_dataIn
  );

  modport master (
`ifdef MEM_ACCESS_CTRL_BYTE_EN
    output req_byte,
`endif
    output req_valid, req_write, req_addr, req_wdata, mem_dataOut,
    input  req_ready, resp_valid, resp_rdata, mem_address, mem_writeEnable, mem_dataIn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Word load/store sequencer over a byte-wide sync-read memory; store latency wordbytes, load wordbytes+1.
// req_ready is low while an access is in flight; MEM_ACCESS_CTRL_BYTE_EN enables single-byte accesses.
module mem_access_ctrl #(
  parameter int addresswidth = 7,
  parameter int width        = 8,
  parameter int wordbytes    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_access_ctrl_if.slave bus
);
  localparam int WW = width * wordbytes;
  localparam int KW = (wordbytes > 1) ? $clog2(wordbytes) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [KW-1:0]           K_LAST = KW'(wordbytes - 1);
  localparam logic [addresswidth-1:0] A_ONE  = addresswidth'(1);

  logic [1:0]              state;
  logic [KW-1:0]           k;
  logic [KW-1:0]           k_last;
  logic [addresswidth-1:0] addr_q;
  logic                    we_q;
  logic [width-1:0]        din_q;
  logic                    rvld_q;
  logic [WW-width-1:0]     wsh;
  logic [WW-width-1:0]     rsh;
  logic [WW-1:0]           rdata_q;
  logic [WW-1:0]           rcat;

`ifdef MEM_ACCESS_CTRL_BYTE_EN
  logic single;
  assign k_last = single ? '0 : K_LAST;
`else
  assign k_last = K_LAST;
`endif

  // Incoming byte lands on top; earlier bytes drift toward bit 0 (little-endian).
  assign rcat = {bus.mem_dataOut, rsh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      rvld_q  <= 1'b0;
      wsh     <= '0;
      rsh     <= '0;
      rdata_q <= '0;
`ifdef MEM_ACCESS_CTRL_BYTE_EN
      single  <= 1'b0;
`endif
    end else begin
      rvld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            k      <= '0;
            addr_q <= bus.req_addr;
            we_q   <= bus.req_write;
            din_q  <= bus.req_wdata[width-1:0];
            wsh    <= bus.req_wdata[WW-1:width];
            state  <= bus.req_write ? WRITE : READ;
`ifdef MEM_ACCESS_CTRL_BYTE_EN
            single <= bus.req_byte;
`endif
          end
        end
        WRITE: begin
          if (k == k_last) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            rvld_q <= 1'b1;
          end else begin
            k      <= k + 1'b1;
            addr_q <= addr_q + A_ONE;
            din_q  <= wsh[width-1:0];
            wsh    <= wsh >> width;
          end
        end
        READ: begin
          // Memory output lags the issued address by one edge, so skip the first.
          if (k != '0) rsh <= rcat[WW-1:width];
          if (k == k_last) begin
            state <= DRAIN;
          end else begin
            k      <= k + 1'b1;
            addr_q <= addr_q + A_ONE;
          end
        end
        DRAIN: begin
          state  <= IDLE;
          rvld_q <= 1'b1;
`ifdef MEM_ACCESS_CTRL_BYTE_EN
          rdata_q <= single ? WW'(bus.mem_dataOut) : rcat;
`else
          rdata_q <= rcat;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = (state == IDLE);
  assign bus.resp_valid      = rvld_q;
  assign bus.resp_rdata      = rdata_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_writeEnable = we_q;
  assign bus.mem_dataIn      = din_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte memory model, scoreboard of expected responses, vector table.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.addresswidth(7), .width(8), .wordbytes(4)) bus ();
  mem_access_ctrl #(.addresswidth(7), .width(8), .wordbytes(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [7:0] mem     [0:127] = '{default: 8'h00};
  logic [7:0] ref_mem [0:127] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.mem_writeEnable) mem[bus.mem_address] <= bus.mem_dataIn;
    bus.mem_dataOut <= mem[bus.mem_address];
  end

  typedef struct { logic [31:0] rdata; int lat; int we; } exp_t;
  typedef struct { bit wr; bit byt; logic [6:0] a; logic [31:0] d; logic [31:0] er; int el; int ew; } vec_t;
  typedef struct { bit wr; logic [6:0] a; logic [31:0] d; } sreq_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   we_cnt = 0, busy_cnt = 0, resp_cnt = 0, last_resp_cyc = 0;
  logic [31:0] last_rdata = 32'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_note(input string name);
    n_chk++;
    $display("FAIL %s: got timeout/unexpected expected none", name);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int a;
    if (!rst_n) begin
      we_cnt = 0; busy_cnt = 0; acc_q.delete();
    end else begin
      if (bus.mem_writeEnable) we_cnt++;
      if (!bus.req_ready) busy_cnt++;
      if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc + 1);
      if (bus.resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        chk("ready_in_resp_cycle", 32'(bus.req_ready), 32'd1);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          fail_note("unexpected_resp");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("latency", 32'(cyc - a), 32'(e.lat));
          chk("we_cycles", 32'(we_cnt), 32'(e.we));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        we_cnt = 0; busy_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [6:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[7'(a + k)];
    return w;
  endfunction

  task automatic present(input bit wr, input bit byt, input logic [6:0] a, input logic [31:0] d,
                         input logic [31:0] er, input int el, input int ew);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
`ifdef MEM_ACCESS_CTRL_BYTE_EN
    bus.req_byte  = byt;
`endif
    exp_q.push_back('{er, el, ew});
    if (wr) begin
      for (int k = 0; k < (byt ? 1 : 4); k++) ref_mem[7'(a + k)] = d[8*k +: 8];
    end else begin
      last_rdata = er;
    end
  endtask

  task automatic do_req(input bit wr, input bit byt, input logic [6:0] a, input logic [31:0] d,
                        input logic [31:0] er, input int el, input int ew);
    int t = 0;
    while (!bus.req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.req_ready) fail_note("ready_timeout");
    present(wr, byt, a, d, er, el, ew);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 7'($urandom);
    bus.req_wdata = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) begin
      fail_note("resp_timeout");
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_mem_address"}, 32'(bus.mem_address), 32'd0);
    chk({tag, "_mem_we"},     32'(bus.mem_writeEnable), 32'd0);
    chk({tag, "_mem_dataIn"}, 32'(bus.mem_dataIn), 32'd0);
  endtask

  vec_t  tbl [7];
  sreq_t sq  [6];
  logic [6:0] ma [9];
  logic [7:0] mv [9];

  initial begin
    int i, t, first_e, exp_span, rc0;
    logic [31:0] er;

    tbl[0] = '{1'b1, 1'b0, 7'h10, 32'hDEADBEEF, 32'h00000000, 4, 4};
    tbl[1] = '{1'b0, 1'b0, 7'h10, 32'h0,        32'hDEADBEEF, 5, 0};
    tbl[2] = '{1'b1, 1'b0, 7'h7E, 32'h11223344, 32'hDEADBEEF, 4, 4};
    tbl[3] = '{1'b0, 1'b0, 7'h7E, 32'h0,        32'h11223344, 5, 0};
    tbl[4] = '{1'b0, 1'b0, 7'h12, 32'h0,        32'h0000DEAD, 5, 0};
    tbl[5] = '{1'b1, 1'b0, 7'h7F, 32'hA1B2C3D4, 32'h0000DEAD, 4, 4};
    tbl[6] = '{1'b0, 1'b0, 7'h7E, 32'h0,        32'hB2C3D444, 5, 0};

    ma = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h7E, 7'h7F, 7'h00, 7'h01, 7'h02};
    mv = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h44, 8'hD4, 8'hC3, 8'hB2, 8'hA1};

    sq[0] = '{1'b1, 7'h40, 32'h89ABCDEF};
    sq[1] = '{1'b0, 7'h40, 32'h0};
    sq[2] = '{1'b1, 7'h44, 32'h01020304};
    sq[3] = '{1'b0, 7'h42, 32'h0};
    sq[4] = '{1'b1, 7'h41, 32'h55667788};
    sq[5] = '{1'b0, 7'h40, 32'h0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef MEM_ACCESS_CTRL_BYTE_EN
    bus.req_byte  = 1'b0;
`endif

    #12;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      do_req(tbl[v].wr, tbl[v].byt, tbl[v].a, tbl[v].d, tbl[v].er, tbl[v].el, tbl[v].ew);
      wait_done();
    end
    for (int m = 0; m < 9; m++) chk("mem_byte_table", 32'(mem[ma[m]]), 32'(mv[m]));

    // Back-to-back stream with req_valid held high and inputs churning while busy.
    i = 0; t = 0; first_e = 0; exp_span = 0;
    while (i < 6 && t < 200) begin
      if (bus.req_ready) begin
        er = sq[i].wr ? last_rdata : ref_word(sq[i].a);
        present(sq[i].wr, 1'b0, sq[i].a, sq[i].d, er, sq[i].wr ? 4 : 5, sq[i].wr ? 4 : 0);
        exp_span += sq[i].wr ? 4 : 5;
        @(posedge clk); #1;
        if (i == 0) first_e = cyc;
        i++;
      end else begin
        bus.req_write = 1'($urandom);
        bus.req_addr  = 7'($urandom);
        bus.req_wdata = $urandom;
        @(posedge clk); #1;
      end
      t++;
    end
    bus.req_valid = 1'b0;
    if (i < 6) fail_note("stream_issue_timeout");
    wait_done();
    chk("stream_span", 32'(last_resp_cyc - first_e), 32'(exp_span + 5));
    for (int m = 8'h40; m < 8'h48; m++) chk("mem_byte_stream", 32'(mem[m]), 32'(ref_mem[m]));

    // Reset in the middle of a store.
    do_req(1'b1, 1'b0, 7'h20, 32'hCAFEF00D, last_rdata, 4, 4);
    wait_done();
    rc0 = resp_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'h20;
    bus.req_wdata = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rdata = 32'h0;
    ref_mem[7'h20] = 8'h44;
    ref_mem[7'h21] = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_resp", 32'(resp_cnt), 32'(rc0));
    chk("midrst_mem20", 32'(mem[7'h20]), 32'h44);
    chk("midrst_mem21", 32'(mem[7'h21]), 32'h33);
    chk("midrst_mem22", 32'(mem[7'h22]), 32'hFE);
    chk("midrst_mem23", 32'(mem[7'h23]), 32'hCA);
    do_req(1'b0, 1'b0, 7'h20, 32'h0, 32'hCAFE3344, 5, 0);
    wait_done();

`ifdef MEM_ACCESS_CTRL_BYTE_EN
    do_req(1'b1, 1'b1, 7'h05, 32'h123456A5, last_rdata, 1, 1);
    wait_done();
    do_req(1'b0, 1'b1, 7'h05, 32'h0, 32'h000000A5, 2, 0);
    wait_done();
    chk("byte_mem04", 32'(mem[7'h04]), 32'h00);
    chk("byte_mem05", 32'(mem[7'h05]), 32'hA5);
    chk("byte_mem06", 32'(mem[7'h06]), 32'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
